// File: rtl/timebase_shift_sequencer.sv
// timebase_shift_sequencer: phase-staggered start-up of N PWM timebase counter enables
//   clockIn, reset       : clock, asynchronous active-high reset
//   start, stop          : sequence start (IDLE only) / abort (any non-IDLE state, wins over start)
//   delay_wr_en/addr/data: shadow delay register write port, takes effect on the next start
//   enable_out           : registered per-channel counter enables
//   busy, all_running    : state != IDLE, state == RUN
module timebase_shift_sequencer #(
    parameter int N_CHANNELS    = 4,
    parameter int COUNTER_WIDTH = 16,
    parameter int ADDR_WIDTH    = 2
) (
    input  logic                     clockIn,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     delay_wr_en,
    input  logic [ADDR_WIDTH-1:0]    delay_wr_addr,
    input  logic [COUNTER_WIDTH-1:0] delay_wr_data,
    output logic [N_CHANNELS-1:0]    enable_out,
    output logic                     busy,
    output logic                     all_running
);
    typedef enum logic [1:0] {IDLE, LOAD, DELAY, RUN} state_t;
    state_t state;
    logic [COUNTER_WIDTH-1:0] shadow [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0] active [N_CHANNELS];
    logic [COUNTER_WIDTH-1:0] cnt [N_CHANNELS];
    assign busy = state != IDLE;
    assign all_running = state == RUN;
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CHANNELS; i++) shadow[i] <= '0;
        end else if (delay_wr_en && int'(delay_wr_addr) < N_CHANNELS) begin
            shadow[delay_wr_addr] <= delay_wr_data;
        end
    end
    always_ff @(posedge clockIn or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            enable_out <= '0;
            for (int i = 0; i < N_CHANNELS; i++) begin
                active[i] <= '0;
                cnt[i] <= '0;
            end
        end else if (state != IDLE && stop) begin
            state <= IDLE;
            enable_out <= '0;
            for (int i = 0; i < N_CHANNELS; i++) cnt[i] <= '0;
        end else if (state == IDLE) begin
            enable_out <= '0;
            if (start && !stop) begin
                active <= shadow;
                state <= LOAD;
            end
        end else if (state == LOAD) begin
            cnt <= active;
            state <= DELAY;
        end else if (state == DELAY) begin
            if (&enable_out) state <= RUN;
            for (int i = 0; i < N_CHANNELS; i++) begin
                if (!enable_out[i]) begin
                    if (cnt[i] != '0) cnt[i] <= cnt[i] - COUNTER_WIDTH'(1);
                    else enable_out[i] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_timebase_shift_sequencer.sv
// tb_timebase_shift_sequencer: scoreboard bench for a 4-channel and a 3-channel sequencer
module tb_timebase_shift_sequencer;
    logic clockIn = 0, reset = 1, start = 0, stop = 0, delay_wr_en = 0;
    logic [1:0] delay_wr_addr = 0;
    logic [15:0] delay_wr_data = 0;
    logic [3:0] en4;
    logic [2:0] en3;
    logic busy4, busy3, ar4, ar3;
    always #5 clockIn = ~clockIn;
    timebase_shift_sequencer #(.N_CHANNELS(4), .COUNTER_WIDTH(16), .ADDR_WIDTH(2)) dut4 (
        .clockIn(clockIn), .reset(reset), .start(start), .stop(stop),
        .delay_wr_en(delay_wr_en), .delay_wr_addr(delay_wr_addr), .delay_wr_data(delay_wr_data),
        .enable_out(en4), .busy(busy4), .all_running(ar4));
    timebase_shift_sequencer #(.N_CHANNELS(3), .COUNTER_WIDTH(16), .ADDR_WIDTH(2)) dut3 (
        .clockIn(clockIn), .reset(reset), .start(start), .stop(stop),
        .delay_wr_en(delay_wr_en), .delay_wr_addr(delay_wr_addr), .delay_wr_data(delay_wr_data),
        .enable_out(en3), .busy(busy3), .all_running(ar3));
    typedef struct {
        logic [3:0] en4;
        logic b4, r4;
        logic [2:0] en3;
        logic b3, r3;
    } exp_t;
    exp_t sb[$];
    int checks = 0, errors = 0;
    int m_sh[4] = '{0, 0, 0, 0};
    int m_d[4] = '{0, 0, 0, 0};
    bit m_act = 0;
    int m_k = 0;
    string ph = "reset";
    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s/%s: observed %0h expected %0h", ph, tag, obs, exp_v);
        end
    endtask
    function automatic exp_t predict();
        exp_t e;
        int mx4, mx3;
        mx4 = 0;
        mx3 = 0;
        for (int i = 0; i < 4; i++) begin
            e.en4[i] = m_act && (m_k >= 2 + m_d[i]);
            if (m_d[i] > mx4) mx4 = m_d[i];
            if (i < 3) begin
                e.en3[i] = m_act && (m_k >= 2 + m_d[i]);
                if (m_d[i] > mx3) mx3 = m_d[i];
            end
        end
        e.b4 = m_act;
        e.b3 = m_act;
        e.r4 = m_act && (m_k >= 3 + mx4);
        e.r3 = m_act && (m_k >= 3 + mx3);
        return e;
    endfunction
    task automatic step(bit st, bit sp, bit we, int wa, int wd);
        exp_t e;
        start = st;
        stop = sp;
        delay_wr_en = we;
        delay_wr_addr = wa[1:0];
        delay_wr_data = wd[15:0];
        if (!m_act) begin
            if (st && !sp) begin
                m_act = 1;
                m_k = 0;
                m_d = m_sh;
            end
        end else if (sp) m_act = 0;
        else m_k++;
        if (we && wa < 4) m_sh[wa] = wd;
        sb.push_back(predict());
        @(posedge clockIn);
        #1;
        start = 0;
        stop = 0;
        delay_wr_en = 0;
        e = sb.pop_front();
        chk("en4", 32'(en4), 32'(e.en4));
        chk("busy4", 32'(busy4), 32'(e.b4));
        chk("run4", 32'(ar4), 32'(e.r4));
        chk("en3", 32'(en3), 32'(e.en3));
        chk("busy3", 32'(busy3), 32'(e.b3));
        chk("run3", 32'(ar3), 32'(e.r3));
    endtask
    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask
    task automatic zeros_now();
        chk("en4", 32'(en4), 0);
        chk("busy4", 32'(busy4), 0);
        chk("run4", 32'(ar4), 0);
        chk("en3", 32'(en3), 0);
        chk("busy3", 32'(busy3), 0);
        chk("run3", 32'(ar3), 0);
    endtask
    initial begin
        repeat (2) @(posedge clockIn);
        #1;
        zeros_now();
        reset = 0;
        ph = "write";
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 3);
        step(0, 0, 1, 2, 5);
        step(0, 0, 1, 3, 1);
        ph = "seq1";
        step(1, 0, 0, 0, 0);
        idle(10);
        ph = "run_start";
        step(1, 0, 0, 0, 0);
        idle(1);
        ph = "stop";
        step(0, 1, 0, 0, 0);
        ph = "seq2";
        step(1, 0, 0, 0, 0);
        idle(10);
        step(0, 1, 0, 0, 0);
        ph = "midwrite";
        step(1, 0, 0, 0, 0);
        idle(2);
        step(0, 0, 1, 2, 1);
        idle(6);
        step(0, 1, 0, 0, 0);
        ph = "restart";
        step(1, 0, 0, 0, 0);
        idle(8);
        step(0, 1, 0, 0, 0);
        ph = "start_stop_idle";
        step(1, 1, 0, 0, 0);
        idle(2);
        ph = "addr3";
        step(0, 0, 1, 3, 0);
        step(1, 0, 0, 0, 0);
        idle(8);
        step(0, 1, 0, 0, 0);
        ph = "async";
        step(1, 0, 0, 0, 0);
        idle(3);
        #3 reset = 1;
        #1 zeros_now();
        #1 reset = 0;
        m_act = 0;
        m_sh = '{0, 0, 0, 0};
        m_d = '{0, 0, 0, 0};
        @(posedge clockIn);
        #1;
        zeros_now();
        ph = "zero_delays";
        step(1, 0, 0, 0, 0);
        idle(4);
        step(0, 1, 0, 0, 0);
        ph = "max_stop";
        for (int a = 0; a < 4; a++) step(0, 0, 1, a, 16'hFFFF);
        step(1, 0, 0, 0, 0);
        idle(999);
        step(0, 1, 0, 0, 0);
        ph = "max_full";
        step(1, 0, 0, 0, 0);
        idle(65538);
        step(0, 1, 0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
